// File: rtl/regfile_rename_pkg.sv
// Shared constants for the rename-aware register file.
// Provides default widths/counts and a helper that turns a register count
// into an index width. No ports.
package regfile_rename_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  localparam int NRP_DEF   = 2;

  // Index width for a register count (NREG is a power of two).
  function automatic int aw_of(input int nreg);
    return $clog2(nreg);
  endfunction

  localparam int AW_DEF = aw_of(NREG_DEF);

endpackage

// File: rtl/regfile_rename_rd_port.sv
// One combinational read port of the rename register file.
// Ports:
//   addr_i        register index to read
//   data_flat_i   all register data, reg r at [r*XLEN +: XLEN]
//   busy_i        per-register busy bits
//   tag_flat_i    all register tags, reg r at [r*TAG_W +: TAG_W]
//   byp_en_i      commit is active this cycle (already qualified by rdy)
//   byp_rd_i/byp_tag_i/byp_data_i  commit destination, tag and data
//   data_o/busy_o/tag_o            read result
module regfile_rd_port
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic [$clog2(NREG)-1:0] addr_i,
  input  logic [NREG*XLEN-1:0]    data_flat_i,
  input  logic [NREG-1:0]         busy_i,
  input  logic [NREG*TAG_W-1:0]   tag_flat_i,
  input  logic                    byp_en_i,
  input  logic [$clog2(NREG)-1:0] byp_rd_i,
  input  logic [TAG_W-1:0]        byp_tag_i,
  input  logic [XLEN-1:0]         byp_data_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    busy_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]  sel_data;
  logic             sel_busy;
  logic [TAG_W-1:0] sel_tag;

  always_comb begin
    sel_data = '0;
    sel_busy = 1'b0;
    sel_tag  = '0;
    for (int r = 0; r < NREG; r++) begin
      if (addr_i == AW'(r)) begin
        sel_data = data_flat_i[r*XLEN +: XLEN];
        sel_busy = busy_i[r];
        sel_tag  = tag_flat_i[r*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    tag_o  = '0;
    if (addr_i != '0) begin
      data_o = sel_data;
      busy_o = sel_busy;
      tag_o  = sel_tag;
      // A commit that retires the current owner is visible in the same cycle.
      if (byp_en_i && (byp_rd_i == addr_i) && sel_busy && (sel_tag == byp_tag_i)) begin
        data_o = byp_data_i;
        busy_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   flush_in                     drop all renames
//   iss_en_in/iss_rd_in/iss_tag_in          issue: rd now owned by tag
//   cmt_en_in/cmt_rd_in/cmt_tag_in/cmt_data_in  commit write
//   rd_addr_in                   packed read addresses, NRP ports
//   rd_data_out/rd_busy_out/rd_tag_out      per-port read results
//   busy_cnt_out                 number of busy registers (registered)
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRP   = NRP_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         iss_en_in,
  input  logic [$clog2(NREG)-1:0]      iss_rd_in,
  input  logic [TAG_W-1:0]             iss_tag_in,
  input  logic                         cmt_en_in,
  input  logic [$clog2(NREG)-1:0]      cmt_rd_in,
  input  logic [TAG_W-1:0]             cmt_tag_in,
  input  logic [XLEN-1:0]              cmt_data_in,
  input  logic [NRP*$clog2(NREG)-1:0]  rd_addr_in,
  output logic [NRP*XLEN-1:0]          rd_data_out,
  output logic [NRP-1:0]               rd_busy_out,
  output logic [NRP*TAG_W-1:0]         rd_tag_out,
  output logic [$clog2(NREG):0]        busy_cnt_out
);

  localparam int AW = aw_of(NREG);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [AW:0]      cnt_q, cnt_d;

  logic iss_ok, cmt_ok, cmt_match, cnt_inc, cnt_dec;

  assign iss_ok    = iss_en_in && (iss_rd_in != '0);
  assign cmt_ok    = cmt_en_in && (cmt_rd_in != '0);
  assign cmt_match = cmt_ok && busy_q[cmt_rd_in] && (tag_q[cmt_rd_in] == cmt_tag_in);
  assign cnt_inc   = iss_ok && !busy_q[iss_rd_in];
  // A matching commit on the register being re-issued leaves it busy.
  assign cnt_dec   = cmt_match && !(iss_ok && (iss_rd_in == cmt_rd_in));

  always_comb begin
    cnt_d = cnt_q;
    if (flush_in)
      cnt_d = '0;
    else if (cnt_inc && !cnt_dec)
      cnt_d = cnt_q + 1'b1;
    else if (cnt_dec && !cnt_inc)
      cnt_d = cnt_q - 1'b1;
  end

  // Later assignments take precedence: issue overrides commit's busy clear,
  // flush overrides both.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      if (cmt_ok) begin
        data_q[cmt_rd_in] <= cmt_data_in;
        if (cmt_match)
          busy_q[cmt_rd_in] <= 1'b0;
      end
      if (flush_in) begin
        busy_q <= '0;
        for (int r = 0; r < NREG; r++)
          tag_q[r] <= '0;
      end else if (iss_ok) begin
        busy_q[iss_rd_in] <= 1'b1;
        tag_q[iss_rd_in]  <= iss_tag_in;
      end
      cnt_q <= cnt_d;
    end
  end

  assign busy_cnt_out = cnt_q;

  logic [NREG*XLEN-1:0]  data_flat;
  logic [NREG*TAG_W-1:0] tag_flat;

  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign data_flat[r*XLEN +: XLEN]  = data_q[r];
    assign tag_flat[r*TAG_W +: TAG_W] = tag_q[r];
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W)
    ) u_rd_port (
      .addr_i      (rd_addr_in[p*AW +: AW]),
      .data_flat_i (data_flat),
      .busy_i      (busy_q),
      .tag_flat_i  (tag_flat),
      .byp_en_i    (cmt_en_in && rdy_in),
      .byp_rd_i    (cmt_rd_in),
      .byp_tag_i   (cmt_tag_in),
      .byp_data_i  (cmt_data_in),
      .data_o      (rd_data_out[p*XLEN +: XLEN]),
      .busy_o      (rd_busy_out[p]),
      .tag_o       (rd_tag_out[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_rename.sv
`timescale 1ns/1ps
module tb_regfile_rename;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TW   = 4;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in, flush_in;
  logic            iss_en_in;
  logic [AW-1:0]   iss_rd_in;
  logic [TW-1:0]   iss_tag_in;
  logic            cmt_en_in;
  logic [AW-1:0]   cmt_rd_in;
  logic [TW-1:0]   cmt_tag_in;
  logic [XLEN-1:0] cmt_data_in;
  logic [NRP*AW-1:0]   rd_addr_in;
  logic [NRP*XLEN-1:0] rd_data_out;
  logic [NRP-1:0]      rd_busy_out;
  logic [NRP*TW-1:0]   rd_tag_out;
  logic [AW:0]         busy_cnt_out;

  always #5 clk_in = ~clk_in;

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TW), .NRP(NRP)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .iss_en_in    (iss_en_in),
    .iss_rd_in    (iss_rd_in),
    .iss_tag_in   (iss_tag_in),
    .cmt_en_in    (cmt_en_in),
    .cmt_rd_in    (cmt_rd_in),
    .cmt_tag_in   (cmt_tag_in),
    .cmt_data_in  (cmt_data_in),
    .rd_addr_in   (rd_addr_in),
    .rd_data_out  (rd_data_out),
    .rd_busy_out  (rd_busy_out),
    .rd_tag_out   (rd_tag_out),
    .busy_cnt_out (busy_cnt_out)
  );

  // kind: 0 data, 1 busy, 2 tag, 3 busy count
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input string n, input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.port = p; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = rd_data_out[e.port*XLEN +: XLEN];
        1:       obs = {31'b0, rd_busy_out[e.port]};
        2:       obs = {28'b0, rd_tag_out[e.port*TW +: TW]};
        default: obs = {26'b0, busy_cnt_out};
      endcase
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    rst_in = 1'b0; flush_in = 1'b0;
    iss_en_in = 1'b0; iss_rd_in = '0; iss_tag_in = '0;
    cmt_en_in = 1'b0; cmt_rd_in = '0; cmt_tag_in = '0; cmt_data_in = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic issue(input int rd, input int tag);
    iss_en_in = 1'b1; iss_rd_in = AW'(rd); iss_tag_in = TW'(tag);
  endtask

  task automatic commit(input int rd, input int tag, input logic [31:0] d);
    cmt_en_in = 1'b1; cmt_rd_in = AW'(rd); cmt_tag_in = TW'(tag); cmt_data_in = d;
  endtask

  task automatic chk_rd(input string n, input int p, input int addr,
                        input logic [31:0] d, input logic b, input logic [3:0] t);
    rd_addr_in[p*AW +: AW] = AW'(addr);
    push({n, ".data"}, 0, p, d);
    push({n, ".busy"}, 1, p, {31'b0, b});
    push({n, ".tag"},  2, p, {28'b0, t});
    #1;
    drain();
  endtask

  task automatic chk_cnt(input string n, input int v);
    push(n, 3, 0, 32'(v));
    drain();
  endtask

  initial begin
    idle();
    rdy_in = 1'b1;
    rd_addr_in = '0;
    rst_in = 1'b1;
    step();

    // preload some state, then reset it away
    commit(5, 0, 32'h1234);
    issue(2, 1);
    step();
    chk_rd("pre_r5", 0, 5, 32'h1234, 1'b0, 4'd0);
    chk_cnt("pre_cnt", 1);
    rst_in = 1'b1;
    step();
    chk_rd("rst_r5", 0, 5, 32'h0, 1'b0, 4'd0);
    chk_rd("rst_r2", 1, 2, 32'h0, 1'b0, 4'd0);
    chk_cnt("rst_cnt", 0);

    // rename then commit with same-cycle bypass; issue is not bypassed
    issue(5, 3);
    chk_rd("iss_nobyp_r5", 1, 5, 32'h0, 1'b0, 4'd0);
    step();
    chk_rd("ren_r5", 0, 5, 32'h0, 1'b1, 4'd3);
    chk_cnt("ren_cnt", 1);
    commit(5, 3, 32'hDEADBEEF);
    chk_rd("byp_r5", 0, 5, 32'hDEADBEEF, 1'b0, 4'd3);
    step();
    chk_rd("cmt_r5", 0, 5, 32'hDEADBEEF, 1'b0, 4'd3);
    chk_cnt("cmt_cnt", 0);

    // stale commit keeps the newer rename
    issue(7, 1);
    step();
    issue(7, 2);
    step();
    chk_cnt("rerename_cnt", 1);
    commit(7, 1, 32'h11);
    chk_rd("stale_nobyp_r7", 0, 7, 32'h0, 1'b1, 4'd2);
    step();
    chk_rd("stale_r7", 0, 7, 32'h11, 1'b1, 4'd2);
    chk_cnt("stale_cnt", 1);

    // issue and commit hit the same register in one cycle
    issue(9, 6);
    step();
    chk_cnt("coll_pre_cnt", 2);
    issue(9, 4);
    commit(9, 6, 32'h55);
    chk_rd("coll_byp_r9", 1, 9, 32'h55, 1'b0, 4'd6);
    step();
    chk_rd("coll_r9", 1, 9, 32'h55, 1'b1, 4'd4);
    chk_cnt("coll_cnt", 2);

    // flush with concurrent issue and commit
    for (int i = 1; i <= 10; i++) begin
      issue(i, i % 16);
      step();
    end
    chk_cnt("preflush_cnt", 10);
    chk_rd("preflush_r3", 0, 3, 32'h0, 1'b1, 4'd3);
    flush_in = 1'b1;
    issue(11, 2);
    commit(3, 3, 32'h33);
    step();
    chk_cnt("flush_cnt", 0);
    chk_rd("flush_r3", 0, 3, 32'h33, 1'b0, 4'd0);
    chk_rd("flush_r11", 1, 11, 32'h0, 1'b0, 4'd0);
    for (int r = 1; r <= 10; r++) begin
      rd_addr_in[0 +: AW] = AW'(r);
      push($sformatf("flush_busy_r%0d", r), 1, 0, 32'h0);
      #0.2;
      drain();
    end

    // register 0 is hardwired
    commit(0, 0, 32'hFF);
    issue(0, 5);
    chk_rd("x0_same", 0, 0, 32'h0, 1'b0, 4'd0);
    step();
    chk_rd("x0_after", 0, 0, 32'h0, 1'b0, 4'd0);
    chk_cnt("x0_cnt", 0);

    // rdy low freezes everything
    rdy_in = 1'b0;
    issue(4, 5);
    commit(3, 0, 32'h99);
    chk_rd("rdy_byp_r3", 1, 3, 32'h33, 1'b0, 4'd0);
    step();
    chk_rd("rdy_r4", 0, 4, 32'h0, 1'b0, 4'd0);
    chk_rd("rdy_r3", 1, 3, 32'h33, 1'b0, 4'd0);
    chk_cnt("rdy_cnt", 0);

    // reset works with rdy low
    rdy_in = 1'b1;
    issue(12, 7);
    step();
    chk_cnt("pre_rst2_cnt", 1);
    rdy_in = 1'b0;
    rst_in = 1'b1;
    step();
    chk_rd("rst2_r3", 0, 3, 32'h0, 1'b0, 4'd0);
    chk_rd("rst2_r12", 1, 12, 32'h0, 1'b0, 4'd0);
    chk_cnt("rst2_cnt", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
